// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RISC-V opcode constants and register-index width helper
package rv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam int NO_OF_REGISTERS = 32;

    // Width of a register index for a register file of n entries
    function automatic int rw_width(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/hazard_sequencer_if.sv
// rtl/hazard_sequencer_if.sv - decode-side hazard interface bundle
interface hazard_sequencer_if #(
    parameter int RW = 5
);
    logic          id_valid;
    logic [6:0]    id_opcode;
    logic [RW-1:0] id_rs1;
    logic [RW-1:0] id_rs2;
    logic [RW-1:0] id_rd;
    logic          ex_branch_taken;
    logic          dmem_busy;

    logic [RW-1:0] rd_ex;
    logic [RW-1:0] rd_mem;
    logic [RW-1:0] rd_wb;
    logic          stall;
    logic          flush_if;
    logic          flush_id;
    logic          freeze;
    logic [31:0]   stall_count;
    logic [31:0]   flush_count;

    // Pipeline side: presents the decode instruction and EX/MEM status
    modport master (
        output id_valid, id_opcode, id_rs1, id_rs2, id_rd, ex_branch_taken, dmem_busy,
        input  rd_ex, rd_mem, rd_wb, stall, flush_if, flush_id, freeze,
        input  stall_count, flush_count
    );

    // Hazard controller side
    modport slave (
        input  id_valid, id_opcode, id_rs1, id_rs2, id_rd, ex_branch_taken, dmem_busy,
        output rd_ex, rd_mem, rd_wb, stall, flush_if, flush_id, freeze,
        output stall_count, flush_count
    );
endinterface

// File: rtl/opcode_class.sv
// rtl/opcode_class.sv - classifies an opcode by register usage and load type
module opcode_class
    import rv_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       writes_rd,
    output logic       uses_rs1,
    output logic       uses_rs2,
    output logic       is_load
);

    // Stores, branches, system and unknown opcodes never produce a writeback
    always_comb begin
        writes_rd = 1'b0;
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        is_load   = 1'b0;
        case (opcode)
            OP_R:      begin writes_rd = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OP_IMM:    begin writes_rd = 1'b1; uses_rs1 = 1'b1; end
            OP_LOAD:   begin writes_rd = 1'b1; uses_rs1 = 1'b1; is_load = 1'b1; end
            OP_STORE:  begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OP_BRANCH: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OP_JAL:    begin writes_rd = 1'b1; end
            OP_JALR:   begin writes_rd = 1'b1; uses_rs1 = 1'b1; end
            OP_LUI:    begin writes_rd = 1'b1; end
            OP_AUIPC:  begin writes_rd = 1'b1; end
            default:   begin uses_rs1 = 1'b1; end
        endcase
    end

endmodule

// File: rtl/hazard_sequencer.sv
// rtl/hazard_sequencer.sv - tracks in-flight destinations and sequences stall/flush/freeze
module hazard_sequencer
    import rv_pkg::*;
#(
    parameter int no_of_registers = NO_OF_REGISTERS,
    localparam int RW = rw_width(no_of_registers)
) (
    input  logic               clk,
    input  logic               rst,
    hazard_sequencer_if.slave  hz
);

    logic          writes_rd;
    logic          uses_rs1;
    logic          uses_rs2;
    logic          is_load;

    logic [RW-1:0] rd_ex_q, rd_ex_d;
    logic [RW-1:0] rd_mem_q, rd_mem_d;
    logic [RW-1:0] rd_wb_q, rd_wb_d;
    logic          load_ex_q, load_ex_d;
    logic [31:0]   stall_count_q, stall_count_d;
    logic [31:0]   flush_count_q, flush_count_d;

    logic          load_use;
    logic          do_freeze;
    logic          do_flush;
    logic          do_stall;

    opcode_class u_opcode_class (
        .opcode    (hz.id_opcode),
        .writes_rd (writes_rd),
        .uses_rs1  (uses_rs1),
        .uses_rs2  (uses_rs2),
        .is_load   (is_load)
    );

    // Hazard detection and priority: freeze over flush over load-use stall
    always_comb begin
        load_use = load_ex_q && (rd_ex_q != '0) && hz.id_valid &&
                   ((uses_rs1 && (hz.id_rs1 == rd_ex_q)) ||
                    (uses_rs2 && (hz.id_rs2 == rd_ex_q)));
        do_freeze = hz.dmem_busy;
        do_flush  = !hz.dmem_busy && hz.ex_branch_taken;
        do_stall  = !hz.dmem_busy && !hz.ex_branch_taken && load_use;
    end

    // Next tracking state: hold on freeze, bubble EX on flush/stall, else advance
    always_comb begin
        rd_ex_d       = rd_ex_q;
        rd_mem_d      = rd_mem_q;
        rd_wb_d       = rd_wb_q;
        load_ex_d     = load_ex_q;
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (!do_freeze) begin
            rd_mem_d = rd_ex_q;
            rd_wb_d  = rd_mem_q;
            if (do_flush || do_stall) begin
                rd_ex_d   = '0;
                load_ex_d = 1'b0;
            end else begin
                rd_ex_d   = (hz.id_valid && writes_rd) ? hz.id_rd : '0;
                load_ex_d = hz.id_valid && is_load;
            end
            if (do_flush) flush_count_d = flush_count_q + 32'd1;
            if (do_stall) stall_count_d = stall_count_q + 32'd1;
        end
    end

    // Tracking registers and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ex_q       <= '0;
            rd_mem_q      <= '0;
            rd_wb_q       <= '0;
            load_ex_q     <= 1'b0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            rd_ex_q       <= rd_ex_d;
            rd_mem_q      <= rd_mem_d;
            rd_wb_q       <= rd_wb_d;
            load_ex_q     <= load_ex_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    // Drive the interface outputs
    always_comb begin
        hz.rd_ex       = rd_ex_q;
        hz.rd_mem      = rd_mem_q;
        hz.rd_wb       = rd_wb_q;
        hz.stall       = do_stall;
        hz.flush_if    = do_flush;
        hz.flush_id    = do_flush;
        hz.freeze      = do_freeze;
        hz.stall_count = stall_count_q;
        hz.flush_count = flush_count_q;
    end

endmodule

// File: tb/tb_hazard_sequencer.sv
// tb/tb_hazard_sequencer.sv - directed self-checking bench for hazard_sequencer
module tb_hazard_sequencer;
    import rv_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    hazard_sequencer_if #(.RW(5)) hz ();

    hazard_sequencer #(.no_of_registers(32)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd);
        hz.id_valid  = 1'b1;
        hz.id_opcode = op;
        hz.id_rs1    = rs1;
        hz.id_rs2    = rs2;
        hz.id_rd     = rd;
        #1;
    endtask

    task automatic idle();
        hz.id_valid  = 1'b0;
        hz.id_opcode = 7'd0;
        hz.id_rs1    = 5'd0;
        hz.id_rs2    = 5'd0;
        hz.id_rd     = 5'd0;
        #1;
    endtask

    task automatic check_rd(input string tag, input logic [4:0] ex, input logic [4:0] mem,
                            input logic [4:0] wb);
        check({tag, ".rd_ex"},  {27'd0, hz.rd_ex},  {27'd0, ex});
        check({tag, ".rd_mem"}, {27'd0, hz.rd_mem}, {27'd0, mem});
        check({tag, ".rd_wb"},  {27'd0, hz.rd_wb},  {27'd0, wb});
    endtask

    task automatic check_ctl(input string tag, input logic st, input logic fl, input logic fz);
        check({tag, ".stall"},    {31'd0, hz.stall},    {31'd0, st});
        check({tag, ".flush_if"}, {31'd0, hz.flush_if}, {31'd0, fl});
        check({tag, ".flush_id"}, {31'd0, hz.flush_id}, {31'd0, fl});
        check({tag, ".freeze"},   {31'd0, hz.freeze},   {31'd0, fz});
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        hz.ex_branch_taken = 1'b0;
        hz.dmem_busy       = 1'b0;
        idle();
        tick();
        tick();
        rst = 1'b0;

        check_rd("reset", 5'd0, 5'd0, 5'd0);
        check_ctl("reset", 1'b0, 1'b0, 1'b0);
        check("reset.stall_count", hz.stall_count, 32'd0);
        check("reset.flush_count", hz.flush_count, 32'd0);

        // add x5,x1,x2 flows down EX/MEM/WB
        issue(OP_R, 5'd1, 5'd2, 5'd5);
        check_ctl("add", 1'b0, 1'b0, 1'b0);
        tick();
        check_rd("add.c1", 5'd5, 5'd0, 5'd0);
        idle();
        tick();
        check_rd("add.c2", 5'd0, 5'd5, 5'd0);
        tick();
        check_rd("add.c3", 5'd0, 5'd0, 5'd5);

        // lw x6 ; add x7,x6,x1 -> one-cycle stall
        issue(OP_LOAD, 5'd1, 5'd0, 5'd6);
        tick();
        check_rd("lw", 5'd6, 5'd0, 5'd0);
        issue(OP_R, 5'd6, 5'd1, 5'd7);
        check_ctl("lu", 1'b1, 1'b0, 1'b0);
        tick();
        check_rd("lu.bubble", 5'd0, 5'd6, 5'd0);
        check("lu.stall_count", hz.stall_count, 32'd1);
        check_ctl("lu.after", 1'b0, 1'b0, 1'b0);
        tick();
        check_rd("lu.enter", 5'd7, 5'd0, 5'd6);

        // lw x6 ; sw x6,0(x1) -> rs2 hazard stalls
        issue(OP_LOAD, 5'd1, 5'd0, 5'd6);
        tick();
        issue(OP_STORE, 5'd1, 5'd6, 5'd0);
        check("sw.stall", {31'd0, hz.stall}, 32'd1);
        tick();
        check("sw.stall_count", hz.stall_count, 32'd2);
        idle();
        tick();

        // lw x0 ; add x8,x0,x0 -> x0 is never a hazard
        issue(OP_LOAD, 5'd1, 5'd0, 5'd0);
        tick();
        check("lwx0.rd_ex", {27'd0, hz.rd_ex}, 32'd0);
        issue(OP_R, 5'd0, 5'd0, 5'd8);
        check("x0.stall", {31'd0, hz.stall}, 32'd0);
        tick();
        check("x0.stall_count", hz.stall_count, 32'd2);

        // Load-use together with a taken branch: flush wins
        issue(OP_LOAD, 5'd1, 5'd0, 5'd6);
        tick();
        issue(OP_R, 5'd6, 5'd1, 5'd7);
        hz.ex_branch_taken = 1'b1;
        #1;
        check_ctl("br_lu", 1'b0, 1'b1, 1'b0);
        tick();
        hz.ex_branch_taken = 1'b0;
        check("br_lu.flush_count", hz.flush_count, 32'd1);
        check("br_lu.stall_count", hz.stall_count, 32'd2);
        check("br_lu.rd_ex", {27'd0, hz.rd_ex}, 32'd0);

        // Drain, then place x9 in MEM and freeze for 3 cycles with a branch pending
        idle();
        tick();
        tick();
        tick();
        issue(OP_IMM, 5'd1, 5'd0, 5'd9);
        tick();
        idle();
        tick();
        check_rd("pre_frz", 5'd0, 5'd9, 5'd0);
        issue(OP_R, 5'd1, 5'd2, 5'd10);
        hz.dmem_busy       = 1'b1;
        hz.ex_branch_taken = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_ctl($sformatf("frz%0d", i), 1'b0, 1'b0, 1'b1);
            tick();
            check_rd($sformatf("frz%0d", i), 5'd0, 5'd9, 5'd0);
            check($sformatf("frz%0d.flush_count", i), hz.flush_count, 32'd1);
            check($sformatf("frz%0d.stall_count", i), hz.stall_count, 32'd2);
        end
        hz.dmem_busy = 1'b0;
        #1;
        check_ctl("pend_br", 1'b0, 1'b1, 1'b0);
        tick();
        check_rd("pend_br", 5'd0, 5'd0, 5'd9);
        check("pend_br.flush_count", hz.flush_count, 32'd2);
        hz.ex_branch_taken = 1'b0;
        #1;
        tick();
        check_rd("post_frz", 5'd10, 5'd0, 5'd0);

        // Reset asserted during a stall cycle
        issue(OP_LOAD, 5'd1, 5'd0, 5'd6);
        tick();
        issue(OP_R, 5'd6, 5'd1, 5'd7);
        check("rst_st.stall", {31'd0, hz.stall}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_rd("rst_st", 5'd0, 5'd0, 5'd0);
        check_ctl("rst_st", 1'b0, 1'b0, 1'b0);
        check("rst_st.stall_count", hz.stall_count, 32'd0);
        check("rst_st.flush_count", hz.flush_count, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_sequencer.md
# hazard_sequencer

Pipeline hazard controller for the 5-stage RISC-V core. Tracks destination registers of in-flight instructions through EX/MEM/WB and feeds them to the forwarding unit as `rd_pre`/`rd_pre_pre`/`rd_pre_pre_pre`. Detects load-use hazards the forwarding paths cannot cover, and sequences stalls, taken-branch flushes and data-memory wait freezes. Sits beside the decode stage and drives PC/IF-ID/ID-EX enables and flushes.

## Interface
- `no_of_registers`, 32, architectural register count; `RW = $clog2(no_of_registers)`
- `clk`  in  1  core clock
- `rst`  in  1  synchronous, active-high reset
- `id_valid`  in  1  decode stage holds a valid instruction
- `id_opcode`  in  7  opcode of the instruction in ID
- `id_rs1`, `id_rs2`, `id_rd`  in  RW  register fields of the instruction in ID
- `ex_branch_taken`  in  1  branch/jump in EX resolved taken
- `dmem_busy`  in  1  data memory cannot complete the MEM access this cycle
- `rd_ex`, `rd_mem`, `rd_wb`  out  RW  tracked destinations; 0 = no writeback
- `stall`  out  1  hold PC and IF/ID; insert bubble into ID/EX
- `flush_if`, `flush_id`  out  1  squash IF/ID and ID/EX contents
- `freeze`  out  1  hold every pipeline register
- `stall_count`, `flush_count`  out  32  performance counters

## Operation
- Writes-rd opcodes: 0110011, 0010011, 0000011 (load), 1101111, 1100111, 0110111, 0010111. All others (store 0100011, branch 1100011, system, unknown) track rd = 0.
- rs1 is used by every opcode except 0110111, 0010111, 1101111. rs2 is used by 0110011, 0100011, 1100011.
- Tracking registers: `rd_ex`/`load_ex` (internal), `rd_mem`, `rd_wb`.
- Priority per cycle: `rst` > freeze > flush > load-use stall > advance.
- Freeze (`dmem_busy=1`):
  - `freeze=1`; `stall`, `flush_*` = 0.
  - All tracking registers and counters hold.
  - A pending `ex_branch_taken` is acted on in the first cycle after `dmem_busy` drops.
- Flush (`ex_branch_taken=1`):
  - `flush_if=flush_id=1`, `stall=0`.
  - Next edge: EX ← bubble (rd 0, load 0), MEM ← EX, WB ← MEM.
  - `flush_count` +1.
- Load-use stall:
  - Condition: `load_ex && rd_ex!=0 && id_valid`, and either (rs1 used && `id_rs1==rd_ex`) or (rs2 used && `id_rs2==rd_ex`).
  - `stall=1`; next edge EX ← bubble, MEM/WB advance; `stall_count` +1.
  - Lasts exactly one cycle, since the load then sits in MEM and is forwarded from there.
- Advance:
  - EX ← (`id_valid` && writes-rd) ? `id_rd` : 0.
  - `load_ex` ← `id_valid && opcode==0000011`.
  - MEM ← EX, WB ← MEM.
- `id_rd==0` tracks as 0; x0 is never a hazard source.
- Counters wrap at 2^32−1 → 0.

## Timing
- `stall`, `flush_if`, `flush_id`, `freeze` are combinational from inputs and tracking registers; valid in the same cycle.
- `rd_ex`/`rd_mem`/`rd_wb` are registered and update on the rising `clk` edge.
- Latency ID→`rd_ex` is 1 cycle, →`rd_mem` 2 cycles, →`rd_wb` 3 cycles, absent stalls and freezes.
- Reset state: all tracking registers 0, `load_ex` 0, counters 0, so every combinational output is 0.
- `rst` asserted mid-stall or mid-freeze clears state at that edge; there is no residual stall.
- `ex_branch_taken` together with a load-use condition: flush wins, no stall, and only `flush_count` increments.

## Structure
- Shared package `rv_pkg`: opcode constants (`OP_R`, `OP_IMM`, `OP_LOAD`, `OP_STORE`, `OP_BRANCH`, `OP_JAL`, `OP_JALR`, `OP_LUI`, `OP_AUIPC`) and a `RW` width function. The forwarding unit and decoder reuse these.
- One natural sub-module, `opcode_class`: combinational decode of `id_opcode` to `writes_rd`, `uses_rs1`, `uses_rs2`, `is_load`.
- The top level holds the tracking registers, the priority logic and the counters.

## Test plan
- Reset then `add x5,x1,x2` (0110011, rd 5) issued → `rd_ex=5`, then `rd_mem=5`, then `rd_wb=5`; `stall`/`flush_*` stay 0.
- `lw x6` followed by `add x7,x6,x1` → `stall=1` for exactly 1 cycle, `rd_ex=0` bubble, `stall_count=1`; the add enters EX next cycle.
- `lw x6` followed by `sw x6,0(x1)` (store uses rs2=6) → `stall=1`; `lw x0` followed by a use of x0 → no stall.
- Load-use condition plus `ex_branch_taken=1` in the same cycle → `flush_if=flush_id=1`, `stall=0`, `flush_count=1`, `stall_count=0`.
- `dmem_busy=1` for 3 cycles with `rd_mem=9` → `freeze=1`, all rd outputs constant and counters unchanged; after release the pipeline advances normally.
- `rst` asserted during a stall cycle → next cycle all outputs 0 and counters 0.
